// File: rtl/change_dispense_sequencer.sv
// change_dispense_sequencer
//   Pays out change (0..MAX_AMOUNT) as greedy coins (50, 10, 5, 1), offering one
//   coin at a time to the ejector over valid/ready, with a GAP_CYCLES idle gap
//   after every accepted coin so the UI can display it.
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   start, amount : payout request (sampled in IDLE only) and change amount
//   abort         : level; cancels an active payout
//   coin_ready    : ejector accepts the offered coin
//   coin_valid    : coin offer valid
//   coin_sel      : 0=1, 1=5, 2=10, 3=50
//   busy          : state is not IDLE (combinational from state register)
//   done          : one-cycle pulse on normal completion
//   remaining     : change still owed
//   coin_count    : coins accepted in the current payout
module change_dispense_sequencer #(
    parameter int GAP_CYCLES = 500_000,
    parameter int MAX_AMOUNT = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] amount,
    input  logic       abort,
    input  logic       coin_ready,
    output logic       coin_valid,
    output logic [1:0] coin_sel,
    output logic       busy,
    output logic       done,
    output logic [6:0] remaining,
    output logic [3:0] coin_count
);

    localparam int         CNT_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [6:0] MAX_A   = 7'(MAX_AMOUNT);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SELECT, OFFER, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [6:0]       remaining_q, remaining_d;
    logic [3:0]       coin_count_q, coin_count_d;
    logic [1:0]       coin_sel_q, coin_sel_d;
    logic             coin_valid_q, coin_valid_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [6:0]       sat_amount;
    logic             handshake;

    function automatic logic [6:0] coin_value(input logic [1:0] sel);
        case (sel)
            2'd0:    coin_value = 7'd1;
            2'd1:    coin_value = 7'd5;
            2'd2:    coin_value = 7'd10;
            default: coin_value = 7'd50;
        endcase
    endfunction

    function automatic logic [1:0] largest_coin(input logic [6:0] rem);
        if (rem >= 7'd50)      largest_coin = 2'd3;
        else if (rem >= 7'd10) largest_coin = 2'd2;
        else if (rem >= 7'd5)  largest_coin = 2'd1;
        else                   largest_coin = 2'd0;
    endfunction

    assign sat_amount = (amount > MAX_A) ? MAX_A : amount;
    // coin_valid_q is only ever high while in OFFER
    assign handshake  = coin_valid_q & coin_ready;

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        coin_count_d = coin_count_q;
        coin_sel_d   = coin_sel_q;
        coin_valid_d = 1'b0;
        done_d       = 1'b0;
        gap_cnt_d    = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d  = sat_amount;
                    coin_count_d = 4'd0;
                    state_d      = (sat_amount == 7'd0) ? DONE : SELECT;
                end
            end
            SELECT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    coin_sel_d = largest_coin(remaining_q);
                    state_d    = OFFER;
                end
            end
            OFFER: begin
                // First OFFER cycle raises coin_valid; the offer then holds until
                // accepted. A handshake is honoured even when abort is also high.
                if (handshake) begin
                    remaining_d  = remaining_q - coin_value(coin_sel_q);
                    coin_count_d = coin_count_q + 4'd1;
                    gap_cnt_d    = '0;
                    state_d      = abort ? IDLE : GAP;
                end else if (abort) begin
                    state_d = IDLE;
                end else begin
                    coin_valid_d = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_cnt_q == GAP_LAST) begin
                    state_d = (remaining_q == 7'd0) ? DONE : SELECT;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            coin_count_q <= '0;
            coin_sel_q   <= '0;
            coin_valid_q <= 1'b0;
            done_q       <= 1'b0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            coin_count_q <= coin_count_d;
            coin_sel_q   <= coin_sel_d;
            coin_valid_q <= coin_valid_d;
            done_q       <= done_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    assign coin_valid = coin_valid_q;
    assign coin_sel   = coin_sel_q;
    assign done       = done_q;
    assign remaining  = remaining_q;
    assign coin_count = coin_count_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_change_dispense_sequencer.sv
module tb_change_dispense_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] amount = '0;
    logic       abort = 1'b0;
    logic       coin_ready = 1'b0;
    logic       coin_valid;
    logic [1:0] coin_sel;
    logic       busy;
    logic       done;
    logic [6:0] remaining;
    logic [3:0] coin_count;

    change_dispense_sequencer #(.GAP_CYCLES(4), .MAX_AMOUNT(99)) dut (
        .clk(clk), .rst(rst), .start(start), .amount(amount), .abort(abort),
        .coin_ready(coin_ready), .coin_valid(coin_valid), .coin_sel(coin_sel),
        .busy(busy), .done(done), .remaining(remaining), .coin_count(coin_count)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int done_cnt = 0;
    int valid_cnt = 0;
    logic prev_valid = 1'b0;
    int exp_q[$];
    int rise_q[$];

    task automatic chk(input string tag, input int obs, input int exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard side: every handshake that the next posedge will take is compared
    // against the next expected coin.
    always @(negedge clk) begin
        if (!rst) begin
            if (coin_valid && coin_ready) begin
                if (exp_q.size() == 0) chk("unexpected_coin_sel", coin_sel, -1);
                else chk("coin_sel", coin_sel, exp_q.pop_front());
            end
            if (coin_valid && !prev_valid) rise_q.push_back(cyc);
            if (coin_valid) valid_cnt++;
            if (done) done_cnt++;
        end
        prev_valid = coin_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk("idle_timeout_busy", busy, 0);
    endtask

    task automatic wait_count(input int target, input int budget);
        int n = 0;
        while (coin_count != 4'(target) && n < budget) begin
            step();
            n++;
        end
        chk("count_timeout", coin_count, target);
    endtask

    task automatic do_start(input int amt);
        amount = 7'(amt);
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, coin_valid, 0);
        chk({tag, "_sel"}, coin_sel, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_remaining"}, remaining, 0);
        chk({tag, "_count"}, coin_count, 0);
    endtask

    initial begin
        // reset
        rst = 1'b1;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        // 1: 67 -> 50,10,5,1,1 with rises 7 cycles apart
        coin_ready = 1'b1;
        exp_q = '{3, 2, 1, 0, 0};
        rise_q.delete();
        done_cnt = 0;
        do_start(67);
        chk("t1_busy_after_start", busy, 1);
        chk("t1_valid_n0", coin_valid, 0);
        step();
        chk("t1_valid_n1", coin_valid, 0);
        step();
        chk("t1_valid_n2", coin_valid, 1);
        wait_idle(200);
        chk("t1_done_high", done, 1);
        step();
        chk("t1_done_one_cycle", done, 0);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_count", coin_count, 5);
        chk("t1_remaining", remaining, 0);
        chk("t1_queue_empty", exp_q.size(), 0);
        chk("t1_rises", rise_q.size(), 5);
        for (int i = 1; i < rise_q.size(); i++)
            chk("t1_rise_spacing", rise_q[i] - rise_q[i-1], 7);

        // 2: 120 saturates to 99
        exp_q = '{3, 2, 2, 2, 2, 1, 0, 0, 0, 0};
        done_cnt = 0;
        do_start(120);
        chk("t2_saturated", remaining, 99);
        wait_idle(400);
        step();
        chk("t2_count", coin_count, 10);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_queue_empty", exp_q.size(), 0);

        // 3: zero amount
        done_cnt = 0;
        valid_cnt = 0;
        do_start(0);
        chk("t3_busy_done_state", busy, 1);
        chk("t3_done_n0", done, 0);
        step();
        chk("t3_done_n1", done, 1);
        chk("t3_idle_n1", busy, 0);
        step();
        chk("t3_done_n2", done, 0);
        chk("t3_valid_never", valid_cnt, 0);
        chk("t3_count", coin_count, 0);
        chk("t3_done_cnt", done_cnt, 1);

        // 4: stall first offer for 7 cycles
        coin_ready = 1'b0;
        exp_q = '{2, 1};
        do_start(15);
        step();
        step();
        for (int i = 0; i < 7; i++) begin
            chk("t4_stall_valid", coin_valid, 1);
            chk("t4_stall_sel", coin_sel, 2);
            chk("t4_stall_remaining", remaining, 15);
            step();
        end
        coin_ready = 1'b1;
        step();
        chk("t4_after_accept_rem", remaining, 5);
        chk("t4_after_accept_valid", coin_valid, 0);
        wait_idle(200);
        step();
        chk("t4_count", coin_count, 2);
        chk("t4_queue_empty", exp_q.size(), 0);

        // 5: abort in second gap, then a fresh payout
        exp_q = '{2, 2, 2};
        done_cnt = 0;
        do_start(30);
        wait_count(2, 200);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort_idle", busy, 0);
        chk("t5_abort_rem", remaining, 10);
        chk("t5_abort_count", coin_count, 2);
        chk("t5_abort_valid", coin_valid, 0);
        repeat (3) step();
        chk("t5_no_done", done_cnt, 0);
        chk("t5_frozen_rem", remaining, 10);
        exp_q = '{0, 0, 0, 0, 0};
        do_start(5);
        exp_q = '{1};
        chk("t5_restart_busy", busy, 1);
        chk("t5_restart_rem", remaining, 5);
        wait_idle(200);
        step();
        chk("t5_restart_count", coin_count, 1);
        chk("t5_restart_done", done_cnt, 1);

        // 6: reset mid-offer, start ignored while busy, abort on handshake
        coin_ready = 1'b0;
        exp_q = '{3};
        do_start(55);
        step();
        step();
        chk("t6_offer_valid", coin_valid, 1);
        rst = 1'b1;
        step();
        chk_all_zero("t6_reset");
        rst = 1'b0;
        exp_q.delete();
        done_cnt = 0;
        exp_q = '{3};
        do_start(55);
        step();
        step();
        do_start(1);
        chk("t6_ignored_start_rem", remaining, 55);
        chk("t6_ignored_start_sel", coin_sel, 3);
        chk("t6_ignored_start_valid", coin_valid, 1);
        coin_ready = 1'b1;
        abort = 1'b1;
        step();
        coin_ready = 1'b0;
        abort = 1'b0;
        chk("t6_hs_abort_idle", busy, 0);
        chk("t6_hs_abort_count", coin_count, 1);
        chk("t6_hs_abort_rem", remaining, 5);
        chk("t6_hs_abort_valid", coin_valid, 0);
        repeat (3) step();
        chk("t6_no_done", done_cnt, 0);
        chk("t6_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
